// File: rtl/l1_request_arbiter_pkg.sv
// l1_request_arbiter_pkg: L1 client IDs, sizing constants and the record types
// shared by the L1 request arbiter and its in-flight read FIFO.
package l1_request_arbiter_pkg;
    localparam int L1_CONNECTIONS      = 4;
    localparam int L1_ARB_MAX_INFLIGHT = 4;
    localparam int L1_ADDR_W           = 32;
    localparam int L1_DATA_W           = 32;
    localparam int L1_BURST_W          = 5;

    typedef enum logic [1:0] {
        L1_DCACHE_ID = 2'd0,
        L1_DMMU_ID   = 2'd1,
        L1_ICACHE_ID = 2'd2,
        L1_IMMU_ID   = 2'd3
    } l1_id_t;

    typedef struct packed {
        logic [L1_ADDR_W-1:0]  addr;
        logic [L1_DATA_W-1:0]  data;
        logic                  rnw;
        logic [L1_BURST_W-1:0] burst;
        l1_id_t                id;
    } l1_arb_req_t;

    typedef struct packed {
        l1_id_t                id;
        logic [L1_BURST_W-1:0] burst;
    } l1_inflight_t;
endpackage

// File: rtl/l1_inflight_fifo.sv
// l1_inflight_fifo: registered FIFO of outstanding read owners/lengths; a push
// and a pop in the same cycle are both honoured, including while full.
module l1_inflight_fifo
    import l1_request_arbiter_pkg::*;
#(
    parameter int DEPTH = L1_ARB_MAX_INFLIGHT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  l1_inflight_t push_data,
    input  logic         pop,
    output l1_inflight_t head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    l1_inflight_t   mem_q [DEPTH];
    l1_inflight_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]    cnt_q, cnt_d;

    assign head  = mem_q[rd_q];
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;

    // next storage, pointers (wrapping modulo DEPTH) and occupancy
    always_comb begin
        mem_d = mem_q;
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        if (push) mem_d[wr_q] = push_data;
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: shares the single L1 memory request port among the four
// L1 clients and steers returning read beats to their owner.
// Build option L1_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module l1_request_arbiter
    import l1_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = L1_CONNECTIONS,
    parameter int MAX_INFLIGHT = L1_ARB_MAX_INFLIGHT,
    parameter int ADDR_W       = L1_ADDR_W,
    parameter int DATA_W       = L1_DATA_W,
    parameter int BURST_W      = L1_BURST_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_rnw,
    input  logic [NUM_REQ*BURST_W-1:0]  req_burst,
    output logic                        mem_request,
    input  logic                        mem_ack,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_rnw,
    output logic [BURST_W-1:0]          mem_burst,
    output l1_id_t                      mem_id,
    input  logic                        mem_rd_valid,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    l1_arb_req_t         mreq_q, mreq_d;
    logic [BURST_W-1:0]  beat_q, beat_d;
    logic [NUM_REQ-1:0]  cand;
    logic                grant;
    logic [IDW-1:0]      win;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    l1_inflight_t        fifo_head;
`ifdef L1_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    l1_inflight_fifo #(.DEPTH(MAX_INFLIGHT)) u_inflight_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ('{id: mreq_q.id, burst: mreq_q.burst}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_request = state_q == ISSUE;
    assign mem_addr    = mreq_q.addr;
    assign mem_data    = mreq_q.data;
    assign mem_rnw     = mreq_q.rnw;
    assign mem_burst   = mreq_q.burst;
    assign mem_id      = mreq_q.id;
    assign rd_data     = mem_rd_data;

    // winner selection; reads are held off while the in-flight FIFO is full
    always_comb begin
        cand  = req_valid & ~(req_rnw & {NUM_REQ{fifo_full}});
        grant = |cand;
        win   = '0;
`ifdef L1_ARB_ROUND_ROBIN_EN
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (cand[rr_ptr_q + IDW'(i)]) win = rr_ptr_q + IDW'(i);
`else
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (cand[i]) win = IDW'(i);
`endif
    end

    // accept/issue FSM: capture the winner in IDLE, hold it on the bus until acked
    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        req_ready = '0;
        fifo_push = 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        if (state_q == IDLE) begin
            if (grant && rst_n) begin
                req_ready[win] = 1'b1;
                mreq_d.addr    = req_addr[win*ADDR_W +: ADDR_W];
                mreq_d.data    = req_data[win*DATA_W +: DATA_W];
                mreq_d.rnw     = req_rnw[win];
                mreq_d.burst   = req_burst[win*BURST_W +: BURST_W];
                mreq_d.id      = l1_id_t'(win);
                state_d        = ISSUE;
`ifdef L1_ARB_ROUND_ROBIN_EN
                rr_ptr_d       = win + 1'b1;
`endif
            end
        end else if (mem_ack) begin
            fifo_push = mreq_q.rnw;
            state_d   = IDLE;
        end
    end

    // read beat routing to the FIFO head's owner; pop after its last beat
    always_comb begin
        rd_valid = '0;
        fifo_pop = 1'b0;
        beat_d   = beat_q;
        if (mem_rd_valid && !fifo_empty) begin
            rd_valid[fifo_head.id] = 1'b1;
            fifo_pop = beat_q == fifo_head.burst;
            beat_d   = fifo_pop ? '0 : beat_q + 1'b1;
        end
    end

    // arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mreq_q   <= '0;
            beat_q   <= '0;
`ifdef L1_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            beat_q   <= beat_d;
`ifdef L1_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

`ifdef ENABLE_SIMULATION_ASSERTIONS
    // a read beat with nothing outstanding is a bus protocol error
    assert property (@(posedge clk) disable iff (!rst_n) mem_rd_valid |-> !fifo_empty);
`endif
endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb_l1_request_arbiter: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model of the arbiter.
module tb_l1_request_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_rnw, rd_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*BW-1:0] req_burst;
    logic            mem_request, mem_ack, mem_rnw, mem_rd_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data, mem_rd_data, rd_data;
    logic [BW-1:0]   mem_burst;
    logic [1:0]      mem_id;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {logic [3:0] valid; logic [3:0] rnw; logic [3:0] exp;} vec_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic rnw; logic [4:0] burst;} txn_t;
    typedef struct {int id; int burst;} inf_t;

    always #5 clk = ~clk;

    l1_request_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_rnw(req_rnw), .req_burst(req_burst),
        .mem_request(mem_request), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_rnw(mem_rnw), .mem_burst(mem_burst), .mem_id(mem_id),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [4:0] b);
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
        req_burst[i*BW +: BW] = b;
        req_rnw[i]            = rnw;
        req_valid[i]          = 1'b1;
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {mem_request, mem_addr, mem_data, mem_rnw, mem_burst, mem_id, req_ready, rd_valid}, '0);
    endtask

    // one read beat presented for a cycle; called and returns at posedge+1
    task automatic beat(input logic [31:0] d, input logic [3:0] exp, input string nm);
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        @(negedge clk);
        chk(nm, rd_valid, exp);
        if (exp != 0) chk({nm, "_data"}, rd_data, d);
        cyc();
        mem_rd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int i, input int lim);
        int found;
        found = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                found = 1;
                break;
            end
            cyc();
        end
        chk("wait_ready", found, 1);
    endtask

    // full request: wait for accept, then ack after dly cycles
    task automatic issue(input int i, input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [4:0] b, input int dly);
        set_req(i, rnw, a, d, b);
        wait_ready(i, 20);
        cyc();
        req_valid[i] = 1'b0;
        repeat (dly) cyc();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("issue_id", mem_id, i);
        cyc();
        mem_ack = 1'b0;
    endtask

    vec_t vecs[8];
    txn_t pend[4][$];
    inf_t inflight[$];
    int   gi[$];
    int   gc[$];
    int   got[$];
    int   exp_e[8];

    initial begin
        req_valid = '0; req_rnw = '0; req_addr = '0; req_data = '0; req_burst = '0;
        mem_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;

        // reset: outputs quiet even with a request and a beat present
        req_valid = 4'b0001;
        mem_rd_valid = 1'b1;
        #2;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        mem_rd_valid = 1'b0;

`ifndef L1_ARB_ROUND_ROBIN_EN
        // table: fixed-priority grant from an idle arbiter with an empty FIFO
        vecs[0] = '{4'b0001, 4'b1111, 4'b0001};
        vecs[1] = '{4'b1111, 4'b1111, 4'b0001};
        vecs[2] = '{4'b1110, 4'b1111, 4'b0010};
        vecs[3] = '{4'b1100, 4'b0000, 4'b0100};
        vecs[4] = '{4'b1000, 4'b1111, 4'b1000};
        vecs[5] = '{4'b1010, 4'b0010, 4'b0010};
        vecs[6] = '{4'b0000, 4'b1111, 4'b0000};
        vecs[7] = '{4'b0101, 4'b0000, 4'b0001};
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                if (vecs[v].valid[i]) set_req(i, vecs[v].rnw[i], 32'h100 * (i + 1), 32'h55 + i, 5'd0);
            end
            @(negedge clk);
            chk("tbl_ready", req_ready, vecs[v].exp);
            cyc();
            req_valid = '0;
            if (vecs[v].exp != 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                chk("tbl_mem", {mem_request, mem_rnw, mem_id, mem_addr},
                    {1'b1, vecs[v].rnw[oh_idx(vecs[v].exp)], 2'(oh_idx(vecs[v].exp)), 32'h100 * (oh_idx(vecs[v].exp) + 1)});
                cyc();
                mem_ack = 1'b0;
                if (vecs[v].rnw[oh_idx(vecs[v].exp)]) beat(32'hBEEF0000 + v, vecs[v].exp, "tbl_beat");
            end
        end
`endif

        // single DCACHE read, burst 3, ack two cycles late
        cyc();
        set_req(0, 1'b1, 32'h8000_0010, 32'h0, 5'd3);
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("single_mem", {mem_request, mem_addr, mem_rnw, mem_burst, mem_id}, {1'b1, 32'h8000_0010, 1'b1, 5'd3, 2'd0});
        cyc();
        @(negedge clk);
        chk("single_hold", {mem_request, req_ready}, {1'b1, 4'b0000});
        cyc();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("single_ack_req", mem_request, 1);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("single_drop_req", mem_request, 0);
        cyc();
        for (int b = 0; b < 4; b++) beat(32'hA0 + b, 4'b0001, "single_beat");
        beat(32'hFF, 4'b0000, "single_empty");

        // all four requesting reads, immediate ack
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000 * (i + 1), 32'h0, 5'd0);
        for (int k = 0; k < 20 && gi.size() < 4; k++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                gi.push_back(oh_idx(req_ready));
                gc.push_back(k);
                chk("cont_onehot", $onehot(req_ready), 1);
            end
            cyc();
            if (gc.size() > 0 && gc[gc.size()-1] == k) req_valid[gi[gi.size()-1]] = 1'b0;
            mem_ack = mem_request;
        end
        cyc();
        mem_ack = 1'b0;
        chk("cont_count", gi.size(), 4);
        for (int k = 0; k < gi.size(); k++) begin
            chk("cont_order", gi[k], k);
            if (k > 0) chk("cont_spacing", gc[k] - gc[k-1], 2);
        end

        // FIFO full: write passes, read waits for the first returned beat
        set_req(3, 1'b1, 32'hC000, 32'h0, 5'd0);
        set_req(1, 1'b0, 32'hD000, 32'hDEAD, 5'd7);
        @(negedge clk);
        chk("full_write_grant", req_ready, 4'b0010);
        cyc();
        req_valid[1] = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("full_write_mem", {mem_rnw, mem_id, mem_data}, {1'b0, 2'd1, 32'hDEAD});
        cyc();
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("full_read_stall", req_ready, 4'b0000);
            cyc();
        end
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'h51;
        @(negedge clk);
        chk("full_first_beat", {rd_valid, req_ready}, {4'b0001, 4'b0000});
        cyc();
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("full_read_grant", req_ready, 4'b1000);
        cyc();
        req_valid[3] = 1'b0;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        beat(32'h52, 4'b0010, "drain_1");
        beat(32'h53, 4'b0100, "drain_2");
        beat(32'h54, 4'b1000, "drain_3");
        beat(32'h55, 4'b1000, "drain_4");
        beat(32'h56, 4'b0000, "drain_empty");

        // interleaved ownership
        issue(2, 1'b1, 32'hA000, 32'h0, 5'd1, 0);
        issue(1, 1'b1, 32'hB000, 32'h0, 5'd0, 1);
        beat(32'hA, 4'b0100, "ilv_a");
        beat(32'hB, 4'b0100, "ilv_b");
        beat(32'hC, 4'b0010, "ilv_c");
        beat(32'hD, 4'b0000, "ilv_empty");

        // reset in the middle of a burst
        issue(2, 1'b1, 32'h4000_0000, 32'h0, 5'd3, 0);
        beat(32'h11, 4'b0100, "rst_beat1");
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'h22;
        @(negedge clk);
        chk("rst_beat2", rd_valid, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stray1", rd_valid, 4'b0000);
        cyc();
        @(negedge clk);
        chk("rst_stray2", rd_valid, 4'b0000);
        cyc();
        mem_rd_valid = 1'b0;

        // DCACHE and ICACHE each issuing four writes back to back
`ifdef L1_ARB_ROUND_ROBIN_EN
        exp_e = '{0, 2, 0, 2, 0, 2, 0, 2};
`else
        exp_e = '{0, 0, 0, 0, 2, 2, 2, 2};
`endif
        begin
            int c0, c2;
            c0 = 4;
            c2 = 4;
            for (int k = 0; k < 40 && got.size() < 8; k++) begin
                if (c0 > 0) set_req(0, 1'b0, 32'h100 + c0, 32'h0, 5'd0); else req_valid[0] = 1'b0;
                if (c2 > 0) set_req(2, 1'b0, 32'h200 + c2, 32'h0, 5'd0); else req_valid[2] = 1'b0;
                mem_ack = mem_request;
                @(negedge clk);
                if (req_ready[0]) begin got.push_back(0); c0--; end
                else if (req_ready[2]) begin got.push_back(2); c2--; end
                cyc();
            end
        end
        req_valid = '0;
        mem_ack = mem_request;
        cyc();
        mem_ack = 1'b0;
        chk("order_count", got.size(), 8);
        for (int k = 0; k < got.size(); k++) chk("order_grant", got[k], exp_e[k]);

        // randomized run against the reference model
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_pre_rand");
        cyc();
        rst_n = 1'b1;
        begin
            bit   busy;
            txn_t cur, t;
            int   cur_id, beats, rr, exp_w, j;
            logic [3:0] exp_rv;
            busy = 0; cur_id = 0; beats = 0; rr = 0;
            cur = '{32'h0, 32'h0, 1'b0, 5'd0};
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i].size() < 2 && $urandom_range(0, 7) == 0) begin
                        t.rnw   = 1'($urandom_range(0, 2) != 0);
                        t.addr  = $urandom;
                        t.data  = $urandom;
                        t.burst = t.rnw ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                        pend[i].push_back(t);
                    end
                    if (pend[i].size() > 0) set_req(i, pend[i][0].rnw, pend[i][0].addr, pend[i][0].data, pend[i][0].burst);
                    else req_valid[i] = 1'b0;
                end
                mem_ack = busy && ($urandom_range(0, 1) == 1);
                mem_rd_valid = inflight.size() > 0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
                mem_rd_data = $urandom;
                @(negedge clk);
                exp_w = -1;
                if (!busy) begin
                    for (int k = 0; k < N; k++) begin
                        j = (rr + k) % N;
                        if (exp_w < 0 && pend[j].size() > 0 && !(pend[j][0].rnw && inflight.size() >= 4)) exp_w = j;
                    end
                end
                chk("rand_ready", req_ready, exp_w >= 0 ? 4'(1 << exp_w) : 4'b0000);
                chk("rand_mem_request", mem_request, busy);
                if (busy) chk("rand_mem_fields", {mem_addr, mem_data, mem_rnw, mem_burst, mem_id},
                              {cur.addr, cur.data, cur.rnw, cur.burst, 2'(cur_id)});
                exp_rv = (mem_rd_valid && inflight.size() > 0) ? 4'(1 << inflight[0].id) : 4'b0000;
                chk("rand_rd_valid", rd_valid, exp_rv);
                if (exp_rv != 0) begin
                    chk("rand_rd_data", rd_data, mem_rd_data);
                    beats++;
                    if (beats > inflight[0].burst) begin
                        void'(inflight.pop_front());
                        beats = 0;
                    end
                end
                if (exp_w >= 0) begin
                    busy = 1;
                    cur = pend[exp_w].pop_front();
                    cur_id = exp_w;
`ifdef L1_ARB_ROUND_ROBIN_EN
                    rr = (exp_w + 1) % N;
`endif
                end else if (busy && mem_ack) begin
                    busy = 0;
                    if (cur.rnw) inflight.push_back('{cur_id, int'(cur.burst)});
                end
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
